// File: rtl/torque_display_pkg.sv
// torque_display_pkg -- shared types and constants for the torque display.
//
// Contents:
//   LED_W     width of one LED bank (9)
//   TORQUE_W  width of the torque magnitude (3)
//   BAR_W     longest bar (7 LEDs)
//   dir_e     drive direction code carried on the instruction input
//   reverse_bar()  mirrors a bar so it grows from the opposite end
package torque_display_pkg;

    localparam int LED_W    = 9;
    localparam int TORQUE_W = 3;
    localparam int BAR_W    = 7;

    typedef enum logic [1:0] {
        DIR_IDLE  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_BOTH  = 2'b11
    } dir_e;

    function automatic logic [BAR_W-1:0] reverse_bar(input logic [BAR_W-1:0] b);
        logic [BAR_W-1:0] r;
        for (int i = 0; i < BAR_W; i++) begin
            r[i] = b[BAR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/torque_display_led_bar.sv
// led_bar -- combinational torque to thermometer-code converter.
//
// Ports:
//   torque  in   TORQUE_W  unsigned magnitude 0..7
//   bar     out  BAR_W     bar[i] = 1 for every i < torque
module led_bar
    import torque_display_pkg::*;
(
    input  logic [TORQUE_W-1:0] torque,
    output logic [BAR_W-1:0]    bar
);

    always_comb begin
        bar = '0;
        for (int i = 0; i < BAR_W; i++) begin
            bar[i] = (torque > i[TORQUE_W-1:0]);
        end
    end

endmodule

// File: rtl/torque_display.sv
// torque_display -- drives two 9-LED banks showing direction and torque.
//
// Ports:
//   clk          in   1  sole clock, rising edge
//   rst          in   1  asynchronous, active-high reset; clears outputs at once
//   enable       in   1  1 = display active, 0 = both banks dark
//   instruction  in   2  dir_e code: IDLE / RIGHT / LEFT / BOTH
//   torque       in   3  bar length 0..7
//   left_LED     out  9  bit 8 = side indicator, bit 7 unused, bits 6:0 bar
//                        growing outward from bit 0 (board centre)
//   right_LED    out  9  bit 0 = side indicator, bit 1 unused, bits 8:2 bar
//                        growing outward from bit 8 (board centre)
//
// Outputs are registered: they show the inputs sampled on the previous edge.
//
// Build option: define TORQUE_DISPLAY_BLINK_EN to blink the bar (not the
// side indicators) at full torque, toggling every BLINK_HALF_PERIOD cycles
// and starting in the lit phase. Without it, no counter is built and the
// parameter is unused.
module torque_display
    import torque_display_pkg::*;
#(
    parameter int BLINK_HALF_PERIOD = 25_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          instruction,
    input  logic [TORQUE_W-1:0] torque,
    output logic [LED_W-1:0]    left_LED,
    output logic [LED_W-1:0]    right_LED
);

    dir_e             dir;
    logic [BAR_W-1:0] bar;
    logic             bar_on;
    logic [BAR_W-1:0] bar_vis;
    logic             left_drv;
    logic             right_drv;
    logic [LED_W-1:0] left_next;
    logic [LED_W-1:0] right_next;

    assign dir = dir_e'(instruction);

    led_bar u_led_bar (
        .torque (torque),
        .bar    (bar)
    );

`ifdef TORQUE_DISPLAY_BLINK_EN
    localparam int CNT_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_HALF_PERIOD - 1);

    logic             blink_active;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_dark;

    assign blink_active = enable && (torque == 3'd7);

    // Any break in the blink condition rewinds to the start of the lit phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt  <= '0;
            blink_dark <= 1'b0;
        end else if (!blink_active) begin
            blink_cnt  <= '0;
            blink_dark <= 1'b0;
        end else if (blink_cnt == CNT_MAX) begin
            blink_cnt  <= '0;
            blink_dark <= ~blink_dark;
        end else begin
            blink_cnt  <= blink_cnt + 1'b1;
        end
    end

    assign bar_on = !(blink_active && blink_dark);
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = (BLINK_HALF_PERIOD > 0);
    assign bar_on = 1'b1;
`endif

    always_comb begin
        left_next  = '0;
        right_next = '0;
        left_drv   = enable && ((dir == DIR_LEFT) || (dir == DIR_BOTH));
        right_drv  = enable && ((dir == DIR_RIGHT) || (dir == DIR_BOTH));
        bar_vis    = bar_on ? bar : '0;
        if (left_drv) begin
            left_next = {1'b1, 1'b0, bar_vis};
        end
        // Right bank grows from bit 8 downward, so the bar is mirrored.
        if (right_drv) begin
            right_next = {reverse_bar(bar_vis), 1'b0, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_LED  <= '0;
            right_LED <= '0;
        end else begin
            left_LED  <= left_next;
            right_LED <= right_next;
        end
    end

endmodule

// File: tb/tb_torque_display.sv
module tb_torque_display;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] instruction;
  logic [2:0] torque;
  logic [8:0] left_LED;
  logic [8:0] right_LED;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_q[$];

  torque_display #(.BLINK_HALF_PERIOD(HALF)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .instruction (instruction),
    .torque      (torque),
    .left_LED    (left_LED),
    .right_LED   (right_LED)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: steady display (no blink)
  function automatic logic [17:0] model(input logic en, input logic [1:0] ins, input logic [2:0] tq);
    logic [8:0] l;
    logic [8:0] r;
    l = '0;
    r = '0;
    if (en && (ins == 2'b10 || ins == 2'b11)) begin
      l[8] = 1'b1;
      for (int k = 0; k < 7; k++) if (k < tq) l[k] = 1'b1;
    end
    if (en && (ins == 2'b01 || ins == 2'b11)) begin
      r[0] = 1'b1;
      for (int k = 0; k < 7; k++) if (k < tq) r[8-k] = 1'b1;
    end
    return {l, r};
  endfunction

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed left=%b right=%b expected left=%b right=%b",
             tag, obs[17:9], obs[8:0], exp[17:9], exp[8:0]);
    end
  endtask

  // drive on negedge, push expected, compare 1 cycle later
  task automatic step_exp(input string tag, input logic en, input logic [1:0] ins,
                          input logic [2:0] tq, input logic [17:0] exp);
    logic [17:0] e;
    @(negedge clk);
    enable = en;
    instruction = ins;
    torque = tq;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {left_LED, right_LED}, e);
    end
  endtask

  task automatic step(input string tag, input logic en, input logic [1:0] ins, input logic [2:0] tq);
    step_exp(tag, en, ins, tq, model(en, ins, tq));
  endtask

  initial begin
    // reset held while inputs are active
    rst = 1'b1;
    enable = 1'b1;
    instruction = 2'b01;
    torque = 3'd3;
    #1;
    check("reset_t0", {left_LED, right_LED}, 18'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {left_LED, right_LED}, 18'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({9'b000000000, 9'b111000001});
    @(posedge clk);
    #1;
    check("first_after_reset", {left_LED, right_LED}, exp_q.pop_front());

    // directed values
    step_exp("left_t5", 1'b1, 2'b10, 3'd5, {9'b100011111, 9'b000000000});
    step_exp("both_t0", 1'b1, 2'b11, 3'd0, {9'b100000000, 9'b000000001});
    step_exp("both_t7", 1'b1, 2'b11, 3'd7, {9'b101111111, 9'b111111101});
    step_exp("disable", 1'b0, 2'b11, 3'd7, 18'd0);
    step_exp("idle_t6", 1'b1, 2'b00, 3'd6, 18'd0);
    step_exp("right_t1", 1'b1, 2'b01, 3'd1, {9'b000000000, 9'b100000001});
    // simultaneous instruction and torque change
    step_exp("swap_l2", 1'b1, 2'b10, 3'd2, {9'b100000011, 9'b000000000});

    // sweep torque with instruction advancing every four steps
    for (int i = 0; i < 32; i++) begin
      step("sweep", 1'b1, 2'(i / 4), 3'(i % 8));
    end

    // random (torque below 7 keeps blink builds steady)
    for (int i = 0; i < 40; i++) begin
      step("random", 1'($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 6)));
    end

    // asynchronous reset mid-display
    step("pre_async", 1'b1, 2'b11, 3'd4);
    rst = 1'b1;
    #1;
    check("async_reset", {left_LED, right_LED}, 18'd0);
    @(posedge clk);
    #1;
    check("async_reset_edge", {left_LED, right_LED}, 18'd0);
    @(negedge clk);
    rst = 1'b0;
    step("post_async", 1'b1, 2'b10, 3'd6);

    // full torque held: blinks with the option, steady without
    step("blink_prep", 1'b1, 2'b01, 3'd0);
    for (int i = 0; i < 3 * HALF; i++) begin
`ifdef TORQUE_DISPLAY_BLINK_EN
      step_exp("blink", 1'b1, 2'b01, 3'd7,
               ((i / HALF) % 2 == 0) ? {9'b0, 9'b111111101} : {9'b0, 9'b000000001});
`else
      step_exp("steady_t7", 1'b1, 2'b01, 3'd7, {9'b0, 9'b111111101});
`endif
    end
    // condition drops, then returns: restarts lit
    step("blink_break", 1'b1, 2'b01, 3'd6);
    step_exp("blink_restart", 1'b1, 2'b01, 3'd7, {9'b0, 9'b111111101});

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/torque_display.md
TORQUE_DISPLAY -- requirements
Module: torque_display

Interface
REQ-001 Parameter BLINK_HALF_PERIOD, default 25_000_000, clk cycles per blink half-period; used only when TORQUE_DISPLAY_BLINK_EN is defined.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 enable  input  1  1 = display active; 0 = all LEDs dark.
REQ-005 instruction  input  2  drive direction code: 00 IDLE, 01 RIGHT, 10 LEFT, 11 BOTH.
REQ-006 torque  input  3  unsigned torque magnitude, 0..7.
REQ-007 left_LED  output  9  left LED bank, board LEDR[17:9]; bit 0 is nearest board centre.
REQ-008 right_LED  output  9  right LED bank, board LEDR[8:0]; bit 8 is nearest board centre.

Function
REQ-009 Inputs sampled each rising clk edge; outputs registered; each output reflects inputs from the previous edge, so latency is exactly 1 cycle.
REQ-010 Bar length N = torque (0..7); N=0 lights no bar LEDs; bars grow outward from board centre.
REQ-011 Left bar: left_LED[N-1:0] = 1; right bar: right_LED[8:8-N+1] = 1.
REQ-012 Side indicator: left_LED[8] = 1 whenever the left side is driven; right_LED[0] = 1 whenever the right side is driven, including N=0.
REQ-013 Left side is driven for instruction LEFT or BOTH; right side is driven for RIGHT or BOTH.
REQ-014 IDLE: both outputs all zero regardless of torque.
REQ-015 left_LED[7] and right_LED[1] are never lit; a bar is at most 7 LEDs long.
REQ-016 enable = 0 forces both outputs to 0 on the next edge; other inputs are ignored.
REQ-017 A simultaneous change of instruction and torque takes effect in the same next cycle with no intermediate state.
REQ-018 An undriven side stays exactly 0 on all 9 bits.

Reset
REQ-019 rst asserted: left_LED = 0 and right_LED = 0 immediately (asynchronously); blink counter and phase are cleared.
REQ-020 On the first rising edge after rst deasserts, outputs follow REQ-009.
REQ-021 rst asserted mid-blink or mid-display overrides all inputs.

Configuration
REQ-022 Macro TORQUE_DISPLAY_BLINK_EN defined: when enable = 1 and torque = 7, the driven bar LEDs toggle every BLINK_HALF_PERIOD cycles, starting in the lit phase; side indicators stay steady.
REQ-023 Blink counter restarts in the lit phase whenever the blink condition becomes false, then true again.
REQ-024 Macro TORQUE_DISPLAY_BLINK_EN undefined: no counter logic is built, and torque = 7 shows a steady bar.

Structure
REQ-025 Package torque_display_pkg: enum dir_e (DIR_IDLE, DIR_RIGHT, DIR_LEFT, DIR_BOTH); constants LED_W = 9 and TORQUE_W = 3.
REQ-026 One sub-module, led_bar: combinational torque to 7-bit thermometer code.
REQ-027 The right bank uses the bit-reversed led_bar output.

Verification
REQ-028 rst = 1, then enable = 1, instruction = 01, torque = 3 -> outputs stay 0 while rst = 1; after 1 edge, right_LED = 111000001 and left_LED = 0.
REQ-029 instruction = 10, torque = 5 -> left_LED = 100011111, right_LED = 0.
REQ-030 instruction = 11, torque = 0 -> left_LED = 100000000, right_LED = 000000001; then torque = 7 -> left_LED = 101111111, right_LED = 111111101.
REQ-031 Any instruction and torque with enable = 0 -> both outputs 0 after 1 edge; instruction = 00, torque = 6 -> both outputs 0.
REQ-032 Sweep torque 0..7 with instruction incrementing each time torque wraps past 3 -> each cycle matches REQ-010 to REQ-015 with 1-cycle latency.
REQ-033 TORQUE_DISPLAY_BLINK_EN defined, BLINK_HALF_PERIOD = 4, instruction = 01, torque = 7 -> right bar lit 4 cycles, dark 4 cycles, repeating; right_LED[0] stays 1.
